// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer running on the free-running reference clock.
// Standby support is compiled in only when PLL_LOCK_CTRL_STDBY_EN is defined.
module pll_lock_ctrl #(
    parameter int RST_CYCLES   = 24,
    parameter int LOCK_STABLE  = 240,
    parameter int LOCK_TIMEOUT = 24000,
    parameter int CNT_W        = 16
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    input  logic       stdby_req,
    output logic       pll_reset,
    output logic       pll_stdby,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] fail_cnt
);
    localparam logic [1:0] S_RESET_PLL = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
`ifdef PLL_LOCK_CTRL_STDBY_EN
    localparam logic [1:0] S_STANDBY   = 2'd3;
`endif

    localparam logic [CNT_W-1:0] RST_N     = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             lock_p0;
    logic             lock_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_nxt;
    logic [CNT_W-1:0] phase_inc;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_nxt;
    logic [CNT_W-1:0] stab_inc;
    logic             fail_evt;

    // extlock is asynchronous to refclk; the synchronizer is intentionally unreset
    always_ff @(posedge refclk) begin
        lock_p0 <= extlock;
        lock_s  <= lock_p0;
    end

    assign phase_inc = phase_cnt + ONE;
    assign stab_inc  = stab_cnt + ONE;

    // Entering RESET_PLL preloads the phase counter with 1 so the entry cycle
    // counts toward RST_CYCLES, matching the release-from-reset case.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        stab_nxt  = stab_cnt;
        fail_evt  = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (phase_cnt == RST_N) begin
                    state_nxt = S_WAIT_LOCK;
                    phase_nxt = '0;
                    stab_nxt  = '0;
                end else begin
                    phase_nxt = phase_inc;
                end
            end
            S_WAIT_LOCK: begin
                phase_nxt = phase_inc;
                stab_nxt  = lock_s ? stab_inc : '0;
                if (lock_s && (stab_inc == STABLE_N)) begin
                    state_nxt = S_RUN;
                end else if (phase_inc == TIMEOUT_N) begin
                    state_nxt = S_RESET_PLL;
                    phase_nxt = ONE;
                    fail_evt  = 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_RESET_PLL;
                    phase_nxt = ONE;
                    fail_evt  = 1'b1;
                end
`ifdef PLL_LOCK_CTRL_STDBY_EN
                else if (stdby_req) begin
                    state_nxt = S_STANDBY;
                end
`endif
            end
`ifdef PLL_LOCK_CTRL_STDBY_EN
            S_STANDBY: begin
                if (!stdby_req) begin
                    state_nxt = S_RESET_PLL;
                    phase_nxt = ONE;
                end
            end
`endif
            default: begin
                state_nxt = S_RESET_PLL;
                phase_nxt = ONE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge refclk) begin
        if (reset) begin
            state     <= S_RESET_PLL;
            phase_cnt <= '0;
            stab_cnt  <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            stab_cnt  <= stab_nxt;
            pll_reset <= (state_nxt == S_RESET_PLL);
            sys_rst   <= (state_nxt != S_RUN);
            ready     <= (state_nxt == S_RUN);
            if (fail_evt) begin
                fail_cnt <= sat_inc(fail_cnt);
            end
        end
    end

`ifdef PLL_LOCK_CTRL_STDBY_EN
    always_ff @(posedge refclk) begin
        if (reset) begin
            pll_stdby <= 1'b0;
        end else begin
            pll_stdby <= (state_nxt == S_STANDBY);
        end
    end
`else
    logic unused_stdby_req;
    assign unused_stdby_req = stdby_req;
    assign pll_stdby = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
`timescale 1ns/1ps
module tb_pll_lock_ctrl;
    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int NV = 37;

    logic       refclk = 1'b0;
    logic       reset = 1'b1;
    logic       extlock = 1'b0;
    logic       stdby_req = 1'b0;
    logic       pll_reset;
    logic       pll_stdby;
    logic       sys_rst;
    logic       ready;
    logic [7:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_ctrl #(
        .RST_CYCLES(RC),
        .LOCK_STABLE(LS),
        .LOCK_TIMEOUT(LT),
        .CNT_W(16)
    ) dut (
        .refclk(refclk),
        .reset(reset),
        .extlock(extlock),
        .stdby_req(stdby_req),
        .pll_reset(pll_reset),
        .pll_stdby(pll_stdby),
        .sys_rst(sys_rst),
        .ready(ready),
        .fail_cnt(fail_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic       rst;
        logic       ext;
        logic       stby;
        logic       e_pll_reset;
        logic       e_pll_stdby;
        logic       e_sys_rst;
        logic       e_ready;
        logic [7:0] e_fail;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int pr, input int ps,
                             input int sr, input int rd, input int fc);
        check({tag, ".pll_reset"}, int'(pll_reset), pr);
        check({tag, ".pll_stdby"}, int'(pll_stdby), ps);
        check({tag, ".sys_rst"},   int'(sys_rst),   sr);
        check({tag, ".ready"},     int'(ready),     rd);
        check({tag, ".fail_cnt"},  int'(fail_cnt),  fc);
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Hold reset for n cycles, check reset values, then release; next tick is cycle 0
    task automatic do_reset(input int n, input logic ext, input string tag);
        reset   = 1'b1;
        extlock = ext;
        for (int i = 0; i < n; i++) tick();
        check_all(tag, 1, 0, 1, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        // Table: 3 reset cycles then cycles 0..33 with a one-cycle extlock drop at cycle 16
        for (int i = 0; i < NV; i++) begin
            int c;
            c = i - 3;
            vecs[i].stby        = 1'b0;
            vecs[i].e_pll_stdby = 1'b0;
            if (i < 3) begin
                vecs[i].rst         = 1'b1;
                vecs[i].ext         = 1'b1;
                vecs[i].e_pll_reset = 1'b1;
                vecs[i].e_sys_rst   = 1'b1;
                vecs[i].e_ready     = 1'b0;
                vecs[i].e_fail      = 8'd0;
            end else begin
                vecs[i].rst         = 1'b0;
                vecs[i].ext         = (c != 16);
                vecs[i].e_pll_reset = (c < 4) || (c >= 18 && c < 22);
                vecs[i].e_ready     = (c >= 12 && c < 18) || (c >= 30);
                vecs[i].e_sys_rst   = !vecs[i].e_ready;
                vecs[i].e_fail      = (c >= 18) ? 8'd1 : 8'd0;
            end
        end

        for (int i = 0; i < NV; i++) begin
            reset     = vecs[i].rst;
            extlock   = vecs[i].ext;
            stdby_req = vecs[i].stby;
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].e_pll_reset), int'(vecs[i].e_pll_stdby),
                      int'(vecs[i].e_sys_rst), int'(vecs[i].e_ready), int'(vecs[i].e_fail));
        end

        // Lock never arrives: 4-cycle pll_reset pulse every 36 cycles, fail_cnt steps
        do_reset(3, 1'b0, "to_rst");
        for (int c = 0; c < 112; c++) begin
            tick();
            check($sformatf("to.pll_reset@%0d", c), int'(pll_reset), int'((c % 36) < 4));
            check($sformatf("to.ready@%0d", c), int'(ready), 0);
            check($sformatf("to.fail@%0d", c), int'(fail_cnt), c / 36);
        end

        // Stability and timeout complete on the same edge: lock wins
        do_reset(3, 1'b0, "tie_rst");
        for (int c = 0; c < 38; c++) begin
            extlock = (c >= 27);
            tick();
            if (c == 35) check("tie.ready@35", int'(ready), 0);
            if (c == 36) begin
                check("tie.ready@36", int'(ready), 1);
                check("tie.pll_reset@36", int'(pll_reset), 0);
                check("tie.fail@36", int'(fail_cnt), 0);
            end
        end

        // Lock toggling 6 high / 1 low in WAIT_LOCK never qualifies, times out at WAIT cycle 32
        begin
            int k;
            k = 0;
            reset = 1'b1;
            for (int i = 0; i < 3; i++) begin
                extlock = ((k % 7) != 6);
                k++;
                tick();
            end
            check_all("tog_rst", 1, 0, 1, 0, 0);
            reset = 1'b0;
            for (int c = 0; c < 45; c++) begin
                extlock = ((k % 7) != 6);
                k++;
                tick();
                check($sformatf("tog.ready@%0d", c), int'(ready), 0);
                check($sformatf("tog.pll_reset@%0d", c), int'(pll_reset),
                      int'((c < 4) || (c >= 36 && c < 40)));
                check($sformatf("tog.fail@%0d", c), int'(fail_cnt), int'(c >= 36));
            end
        end

        // Reset mid-WAIT_LOCK clears everything, including fail_cnt, next cycle
        reset   = 1'b1;
        extlock = 1'b1;
        tick();
        check_all("midwait_rst", 1, 0, 1, 0, 0);
        reset = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            tick();
            check($sformatf("rs.pll_reset@%0d", c), int'(pll_reset), int'(c < 4));
            check($sformatf("rs.ready@%0d", c), int'(ready), int'(c >= 12));
            check($sformatf("rs.sys_rst@%0d", c), int'(sys_rst), int'(c < 12));
        end

`ifdef PLL_LOCK_CTRL_STDBY_EN
        // Standby request in RUN; extlock dropped while in STANDBY must be ignored
        for (int c = 14; c <= 19; c++) begin
            stdby_req = 1'b1;
            extlock   = (c < 15) || (c >= 19);
            tick();
            check_all($sformatf("stby@%0d", c), 0, 1, 1, 0, 0);
        end
        for (int c = 20; c <= 32; c++) begin
            stdby_req = 1'b0;
            tick();
            check_all($sformatf("wake@%0d", c), int'(c < 24), 0, int'(c < 32), int'(c >= 32), 0);
        end
        // Reset mid-STANDBY
        stdby_req = 1'b1;
        tick();
        check("stby2.pll_stdby", int'(pll_stdby), 1);
        reset = 1'b1;
        tick();
        check_all("midstby_rst", 1, 0, 1, 0, 0);
        reset     = 1'b0;
        stdby_req = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            tick();
            check($sformatf("rs2.ready@%0d", c), int'(ready), int'(c >= 12));
        end
`else
        // Without standby support the request is ignored in RUN
        for (int c = 14; c <= 22; c++) begin
            stdby_req = 1'b1;
            tick();
            check_all($sformatf("nostby@%0d", c), 0, 0, 0, 1, 0);
        end
        stdby_req = 1'b0;
`endif

        // fail_cnt saturates at 255 after more than 256 timeouts
        do_reset(2, 1'b0, "sat_rst");
        for (int c = 0; c < 257 * 36 + 2; c++) tick();
        check("sat.fail_cnt", int'(fail_cnt), 255);
        check("sat.ready", int'(ready), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Control-side companion to the PLL wrapper: drives the PLL `reset` and `stdby` inputs and consumes its `extlock` output. It sequences PLL reset, qualifies lock over a stability window, retries on lock timeout, and issues a held system reset plus a `ready` flag to downstream logic. It runs on the free-running board reference clock, never on the PLL output, so it keeps operating while the PLL is unlocked or stopped.

## Interface
- `RST_CYCLES`, default 24: cycles `pll_reset` is held high per attempt (1 µs at 24 MHz).
- `LOCK_STABLE`, default 240: consecutive synchronized-lock cycles required before RUN.
- `LOCK_TIMEOUT`, default 24000: maximum WAIT_LOCK cycles before a retry.
- `CNT_W`, default 16: width of the shared phase counter; must hold the largest of the three counts.

- `refclk` in 1: reference clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `extlock` in 1: PLL lock, asynchronous to `refclk`.
- `stdby_req` in 1: standby request, level, synchronous to `refclk`.
- `pll_reset` out 1: to PLL `reset`.
- `pll_stdby` out 1: to PLL `stdby`.
- `sys_rst` out 1: active-high reset for downstream logic.
- `ready` out 1: PLL locked and qualified.
- `fail_cnt` out 8: count of lock timeouts plus lock losses, saturating.

## Operation
- `extlock` passes through a 2-FF synchronizer to give `lock_s`. The synchronizer flops are not reset.
- All outputs are registered.
- While `reset`=1: state = RESET_PLL, counters = 0, `pll_reset`=1, `pll_stdby`=0, `sys_rst`=1, `ready`=0, `fail_cnt`=0.
- RESET_PLL:
  - `pll_reset`=1, `sys_rst`=1, `ready`=0.
  - After RST_CYCLES cycles, go to WAIT_LOCK and clear the counters.
- WAIT_LOCK:
  - `pll_reset`=0.
  - Stability counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - Timeout counter increments every cycle.
  - When stability reaches LOCK_STABLE, go to RUN.
  - Otherwise, when timeout reaches LOCK_TIMEOUT, go to RESET_PLL and increment `fail_cnt`.
  - If both conditions occur in the same cycle, lock wins.
- RUN:
  - `sys_rst`=0, `ready`=1.
  - If `lock_s`=0, go to RESET_PLL and increment `fail_cnt`.
  - Otherwise, if `stdby_req`=1, go to STANDBY.
  - Lock loss has priority over `stdby_req`.
- STANDBY:
  - `pll_stdby`=1, `sys_rst`=1, `ready`=0.
  - `extlock` is ignored in this state.
  - When `stdby_req`=0, go to RESET_PLL with `pll_stdby`=0.
- `stdby_req` is honoured only in RUN. In other states it stays pending, because it is a level.
- `fail_cnt` saturates at 255 and clears only on `reset`.
- `reset` asserted in any state overrides everything next cycle, including mid-STANDBY and mid-WAIT_LOCK.

## Timing
- Cycle 0 is the first edge at which `reset` is sampled low. That cycle is the first RESET_PLL cycle.
- `pll_reset`=1 on cycles 0..RST_CYCLES−1.
- WAIT_LOCK runs from cycle RST_CYCLES onward.
- With `lock_s` continuously high, `ready`=1 and `sys_rst`=0 from cycle RST_CYCLES+LOCK_STABLE.
- Lock-loss latency:
  - `extlock` falling edge → `lock_s` low: 2 cycles.
  - `lock_s` low in RUN → `sys_rst`=1, `ready`=0, `pll_reset`=1: next cycle.
- `sys_rst` asserts in the same cycle that `ready` drops, and deasserts in the same cycle that `ready` rises.
- Downstream logic in the `clk0_out` domain must resynchronize the deassertion of `sys_rst`.
- A glitch of `extlock` low for at least 1 `refclk` cycle while in RUN always forces a full retry.

## Configuration
- Macro: `PLL_LOCK_CTRL_STDBY_EN`.
- Defined: STANDBY state and `pll_stdby` behave as described above.
- Undefined:
  - STANDBY state is not synthesized.
  - `stdby_req` is ignored.
  - `pll_stdby` is tied to 0.
  - The port list is unchanged.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.

- `extlock` held 1, `reset` released → `pll_reset` high on cycles 0–3; `ready`=1 and `sys_rst`=0 from cycle 12; `fail_cnt`=0.
- `extlock` held 0 → `pll_reset` pulses 4 cycles every 36 cycles; `fail_cnt` = 1, 2, 3 after each timeout; `ready` stays 0.
- In RUN, `extlock` dropped 1 cycle → 3 cycles later `sys_rst`=1 and `ready`=0; `fail_cnt`+1; with `extlock` restored, `ready` returns 12 cycles after reentering RESET_PLL.
- In WAIT_LOCK, `extlock` toggles high 6 cycles / low 1 → never reaches RUN; timeout retry occurs at cycle 32 of WAIT_LOCK.
- With macro defined: `stdby_req`=1 in RUN → next cycle `pll_stdby`=1, `sys_rst`=1; `stdby_req`=0 → `pll_stdby`=0, `pll_reset`=1 for 4 cycles, then `ready` after 8 more. With macro undefined: `stdby_req` has no effect.
- `reset` asserted mid-STANDBY or mid-WAIT_LOCK → next cycle all outputs take their reset values and `fail_cnt`=0; the full sequence restarts.
